// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hazard_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // ID/EX control bundle. A bubble replaces it with all-zero controls.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] wb_sel;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t NOP_CTRL = '0;

  // Applies bubble_ex to a decoded control bundle on its way into ID/EX.
  function automatic id_ex_ctrl_t apply_bubble(input id_ex_ctrl_t ctrl, input logic bubble);
    return bubble ? NOP_CTRL : ctrl;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
// Latency: count reflects an enabled cycle after the following clock edge.
// Backpressure: none; counts every enabled cycle.
// Ports: clk, rst (sync, active-high), en (count this cycle), cnt (current value).
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush, data-memory wait-states.
// Latency: strobes are combinational from registered state and current-cycle inputs.
// Backpressure: a memory wait freezes the whole front end (stall_mem) until mem_ready.
// Ports: clk, rst (sync, active-high); ID/EX/MEM hazard inputs; strobes stall_if, bubble_ex,
//   flush_ifid, stall_mem; sticky mem_err; perf counters cnt_stall/cnt_flush.
// Build option: define HAZARD_PERF_CNT_EN to build the perf counters, else they read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_tkn,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             stall_mem,
  output logic             mem_err,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic load_use;
  logic mem_miss;

  assign load_use = ex_MemRead && (ex_rd != REG_X0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_miss = mem_req && !mem_ready;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    stall_if   = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    stall_mem  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_miss) begin
          // The first missed cycle already counts as one wait-state.
          stall_mem  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else if (ex_branch_tkn) begin
          // Kill the wrong-path instructions in IF/ID and ID; PC takes the target.
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX/ID are frozen, so their hazards are re-evaluated after the thaw.
        stall_mem = 1'b1;
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          // wait_cnt counts completed wait-state cycles; it stops at MEM_TIMEOUT.
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          if (wait_cnt_d == WCNT_W'(MEM_TIMEOUT)) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      ERR: begin
        stall_mem = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      stall_if   = 1'b0;
      bubble_ex  = 1'b0;
      flush_ifid = 1'b0;
      stall_mem  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_if || stall_mem),
    .cnt (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush_ifid),
    .cnt (flush_cnt)
  );

  // Counters are registered; mask them so every output reads 0 while rst is held.
  assign cnt_stall = rst ? '0 : stall_cnt;
  assign cnt_flush = rst ? '0 : flush_cnt;
`else
  assign cnt_stall = '0;
  assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Strobe vector order: {stall_if, bubble_ex, flush_ifid, stall_mem, mem_err}.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_tkn;
  logic             mem_req, mem_ready;
  logic             stall_if, bubble_ex, flush_ifid, stall_mem, mem_err;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  int checks = 0;
  int errors = 0;

  wire [4:0] strb = {stall_if, bubble_ex, flush_ifid, stall_mem, mem_err};

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rd         (ex_rd),
    .ex_MemRead    (ex_MemRead),
    .ex_branch_tkn (ex_branch_tkn),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .stall_if      (stall_if),
    .bubble_ex     (bubble_ex),
    .flush_ifid    (flush_ifid),
    .stall_mem     (stall_mem),
    .mem_err       (mem_err),
    .cnt_stall     (cnt_stall),
    .cnt_flush     (cnt_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_MemRead = 1'b0; ex_branch_tkn = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_MemRead = 1'b1; ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Hazard inputs present while rst=1 must not reach any output.
    rst = 1'b1;
    set_load_use(5'd3);
    ex_branch_tkn = 1'b1; mem_req = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL reset_strobes got %b exp 00000", strb); errors++;
    end
    checks++;
    if ({cnt_stall, cnt_flush} !== '0) begin
      $display("FAIL reset_cnts got %h/%h exp 0/0", cnt_stall, cnt_flush); errors++;
    end
    cyc();
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL post_reset_idle got %b exp 00000", strb); errors++;
    end
    cyc();
  endtask

  task automatic test_load_use();
    set_load_use(5'd5);
    #1;
    checks++;
    if (strb !== 5'b11000) begin
      $display("FAIL load_use_rs1 got %b exp 11000", strb); errors++;
    end
    cyc();
    // Next cycle EX holds the bubble: no further stall.
    idle();
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL load_use_one_cycle got %b exp 00000", strb); errors++;
    end
    cyc();
    set_load_use(5'd0);
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL load_use_x0 got %b exp 00000", strb); errors++;
    end
    cyc();
    idle();
    ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b11000) begin
      $display("FAIL load_use_rs2 got %b exp 11000", strb); errors++;
    end
    cyc();
    idle();
    ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL load_use_unused_rs1 got %b exp 00000", strb); errors++;
    end
    cyc();
    idle();
    ex_MemRead = 1'b0; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL load_use_not_load got %b exp 00000", strb); errors++;
    end
    cyc();
    idle();
  endtask

  task automatic test_branch();
    set_load_use(5'd4);
    ex_branch_tkn = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b01100) begin
      $display("FAIL branch_over_load_use got %b exp 01100", strb); errors++;
    end
    cyc();
    idle();
    ex_branch_tkn = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b01100) begin
      $display("FAIL branch_alone got %b exp 01100", strb); errors++;
    end
    cyc();
    idle();
    // Zero-wait memory access: no strobe.
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL mem_zero_wait got %b exp 00000", strb); errors++;
    end
    cyc();
    idle();
  endtask

  task automatic test_mem_wait();
    int stalls;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1;
      mem_ready = (i == 3);
      #1;
      if (stall_mem === 1'b1 && strb === 5'b00010) stalls++;
      cyc();
    end
    checks++;
    if (stalls !== 4) begin
      $display("FAIL mem_wait_stall_cycles got %0d exp 4", stalls); errors++;
    end
    // Back in RUN: a load-use hit is acted on again.
    idle();
    set_load_use(5'd6);
    #1;
    checks++;
    if (strb !== 5'b11000) begin
      $display("FAIL mem_wait_back_to_run got %b exp 11000", strb); errors++;
    end
    cyc();
    idle();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      checks++;
      if (strb !== 5'b00010) begin
        $display("FAIL timeout_wait%0d got %b exp 00010", i, strb); errors++;
      end
      cyc();
    end
    #1;
    checks++;
    if (strb !== 5'b00011) begin
      $display("FAIL timeout_err got %b exp 00011", strb); errors++;
    end
    cyc();
    // ERR is sticky even when memory answers and a branch resolves.
    mem_ready = 1'b1; ex_branch_tkn = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b00011) begin
      $display("FAIL timeout_sticky got %b exp 00011", strb); errors++;
    end
    cyc();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b00000) begin
      $display("FAIL timeout_rst_outputs got %b exp 00000", strb); errors++;
    end
    cyc();
    rst = 1'b0;
    set_load_use(5'd8);
    #1;
    checks++;
    if (strb !== 5'b11000) begin
      $display("FAIL timeout_rst_to_run got %b exp 11000", strb); errors++;
    end
    cyc();
    idle();
  endtask

  task automatic test_branch_in_wait();
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc();
    // MEM_WAIT: branch and load-use both ignored.
    ex_branch_tkn = 1'b1;
    set_load_use(5'd11);
    #1;
    checks++;
    if (strb !== 5'b00010) begin
      $display("FAIL wait_ignores_branch got %b exp 00010", strb); errors++;
    end
    cyc();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (strb !== 5'b00010) begin
      $display("FAIL wait_ready_cycle got %b exp 00010", strb); errors++;
    end
    cyc();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (strb !== 5'b01100) begin
      $display("FAIL wait_branch_after_thaw got %b exp 01100", strb); errors++;
    end
    cyc();
    idle();
  endtask

  task automatic test_perf();
    do_reset();
    set_load_use(5'd5); cyc();
    idle();             cyc();
    set_load_use(5'd6); cyc();
    idle(); ex_branch_tkn = 1'b1; cyc();
    idle();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (cnt_stall !== 4'd2 || cnt_flush !== 4'd1) begin
      $display("FAIL perf_counts got %0d/%0d exp 2/1", cnt_stall, cnt_flush); errors++;
    end
    for (int i = 0; i < 13; i++) begin
      set_load_use(5'd12);
      cyc();
    end
    #1;
    checks++;
    if (cnt_stall !== 4'd15) begin
      $display("FAIL perf_preload got %0d exp 15", cnt_stall); errors++;
    end
    cyc();
    #1;
    checks++;
    if (cnt_stall !== 4'd0) begin
      $display("FAIL perf_wrap got %0d exp 0", cnt_stall); errors++;
    end
`else
    checks++;
    if (cnt_stall !== 4'd0 || cnt_flush !== 4'd0) begin
      $display("FAIL perf_tied_off got %0d/%0d exp 0/0", cnt_stall, cnt_flush); errors++;
    end
`endif
    idle();
    cyc();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_branch_in_wait();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
